// File: rtl/return_addr_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack_pkg
// Description : Shared processor package for the return-address stack.
//               Holds the default geometry of the stack and the encoding of
//               its two-state control FSM.
//               Contents:
//                 c_STACK_DEPTH - default number of return-address entries
//                 c_ADDR_W      - default width of a stored program address
//                 rasState_t    - FSM state type (RUN=0, FAULT=1)
// Revision    : 1.0 - initial release
// ============================================================================
package return_addr_stack_pkg;

    localparam int unsigned c_STACK_DEPTH = 8;
    localparam int unsigned c_ADDR_W      = 12;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } rasState_t;

endpackage : return_addr_stack_pkg
`default_nettype wire

// File: rtl/return_addr_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem
// Description : Storage array for the return-address stack.
//               STACK_DEPTH x ADDR_W registers with one synchronous write
//               port and one combinational read port. Contents are not reset.
//               Ports:
//                 clock  - in  : rising-edge write clock
//                 wrEn   - in  : write enable
//                 wrAddr - in  : write entry index
//                 wrData - in  : write data
//                 rdAddr - in  : read entry index
//                 rdData - out : entry[rdAddr], combinational
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic                           clock,
    input  logic                           wrEn,
    input  logic [$clog2(STACK_DEPTH)-1:0] wrAddr,
    input  logic [ADDR_W-1:0]              wrData,
    input  logic [$clog2(STACK_DEPTH)-1:0] rdAddr,
    output logic [ADDR_W-1:0]              rdData
);

    logic [ADDR_W-1:0] r_entry [STACK_DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            r_entry[wrAddr] <= wrData;
        end
    end

    assign rdData = r_entry[rdAddr];

endmodule : stack_mem
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Hardware return-address stack with overflow/underflow
//               detection. Any illegal access (push when full, pop when
//               empty) freezes the stack in FAULT until clearErr.
//               Ports:
//                 clock       - in  : single clock, rising edge
//                 init_signal - in  : synchronous active-low reset
//                 push        - in  : store pushData on top (call)
//                 pop         - in  : remove top entry (return)
//                 pushData    - in  : return address to store
//                 clearErr    - in  : flush stack, clear flags, leave FAULT
//                 topOfStack  - out : entry[depth-1], 0 when empty
//                 depth       - out : number of valid entries
//                 stackEmpty  - out : depth == 0
//                 stackFull   - out : depth == STACK_DEPTH
//                 overflow    - out : sticky, push attempted while full
//                 underflow   - out : sticky, pop attempted while empty
//                 fault       - out : FSM is in FAULT
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = c_STACK_DEPTH,
    parameter int unsigned ADDR_W      = c_ADDR_W
) (
    input  logic                         clock,
    input  logic                         init_signal,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            pushData,
    input  logic                         clearErr,
    output logic [ADDR_W-1:0]            topOfStack,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         stackEmpty,
    output logic                         stackFull,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         fault
);

    localparam int unsigned          c_IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned          c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(STACK_DEPTH);

    rasState_t           r_state;
    logic [c_CNT_W-1:0]  r_depth;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_empty;
    logic                w_full;
    logic [c_IDX_W-1:0]  w_depthIdx;
    logic [c_IDX_W-1:0]  w_topIdx;
    logic                w_wrEn;
    logic [c_IDX_W-1:0]  w_wrAddr;
    logic [ADDR_W-1:0]   w_rdData;

    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == c_FULL);
    // Low bits only: the index is used for writing at depth, which is never
    // done when full, so the dropped MSB is always zero there.
    assign w_depthIdx = r_depth[c_IDX_W-1:0];
    // Wraps when empty; the read result is masked in that case.
    assign w_topIdx   = w_depthIdx - c_IDX_W'(1);

    // Write port control. Mirrors the write cases of the FSM below; reset,
    // FAULT and clearErr all suppress the write.
    always_comb begin
        w_wrEn   = 1'b0;
        w_wrAddr = w_depthIdx;
        if (init_signal && (r_state == RUN) && !clearErr) begin
            if (push && pop) begin
                // Tail-call replace, or a push into slot 0 when empty.
                w_wrEn   = 1'b1;
                w_wrAddr = w_empty ? '0 : w_topIdx;
            end else if (push && !w_full) begin
                w_wrEn   = 1'b1;
                w_wrAddr = w_depthIdx;
            end
        end
    end

    stack_mem #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_stack_mem (
        .clock  (clock),
        .wrEn   (w_wrEn),
        .wrAddr (w_wrAddr),
        .wrData (pushData),
        .rdAddr (w_topIdx),
        .rdData (w_rdData)
    );

    always_ff @(posedge clock) begin
        if (!init_signal) begin
            r_state     <= RUN;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (clearErr) begin
                        r_depth     <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end else if (push && pop) begin
                        if (w_empty) begin
                            // Nothing to return from: still record the call,
                            // but flag the bad return.
                            r_depth     <= c_CNT_W'(1);
                            r_underflow <= 1'b1;
                            r_state     <= FAULT;
                        end
                    end else if (push) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                            r_state    <= FAULT;
                        end else begin
                            r_depth <= r_depth + c_CNT_W'(1);
                        end
                    end else if (pop) begin
                        if (w_empty) begin
                            r_underflow <= 1'b1;
                            r_state     <= FAULT;
                        end else begin
                            r_depth <= r_depth - c_CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (clearErr) begin
                        r_depth     <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign topOfStack = w_empty ? '0 : w_rdData;
    assign depth      = r_depth;
    assign stackEmpty = w_empty;
    assign stackFull  = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign fault      = (r_state == FAULT);

endmodule : return_addr_stack
`default_nettype wire

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, number of return-address entries (power of two, ≥2).
REQ-002 SHALL have parameter ADDR_W, default 12, width of a stored program address.
REQ-003 SHALL have port clock  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port init_signal  in  1  reset; synchronous and active-low.
REQ-005 SHALL have port push  in  1  store pushData on top of stack (call).
REQ-006 SHALL have port pop  in  1  remove top entry (return).
REQ-007 SHALL have port pushData  in  ADDR_W  return address to store.
REQ-008 SHALL have port clearErr  in  1  leave FAULT state and flush the stack.
REQ-009 SHALL have port topOfStack  out  ADDR_W  current top entry, combinational from stored state.
REQ-010 SHALL have port depth  out  log2(STACK_DEPTH)+1  number of valid entries.
REQ-011 SHALL have port stackEmpty  out  1  depth==0.
REQ-012 SHALL have port stackFull  out  1  depth==STACK_DEPTH.
REQ-013 SHALL have port overflow  out  1  sticky; push attempted while full.
REQ-014 SHALL have port underflow  out  1  sticky; pop attempted while empty.
REQ-015 SHALL have port fault  out  1  high while FSM is in FAULT.

Function
REQ-016 SHALL implement a two-state FSM: RUN, FAULT.
REQ-017 In RUN, push only, not full: entry[depth] <= pushData, depth +1 at the edge.
REQ-018 In RUN, pop only, not empty: depth -1 at the edge; popped entry contents are not cleared.
REQ-019 topOfStack SHALL equal entry[depth-1] when depth>0 and 0 when empty, so the caller samples the return address in the same cycle pop is asserted.
REQ-020 In RUN, push and pop together with depth>0: entry[depth-1] <= pushData, depth unchanged (tail-call replace).
REQ-021 In RUN, push and pop together with depth==0: treated as a push (depth becomes 1); underflow set; FSM enters FAULT.
REQ-022 In RUN, push while full: no write, depth unchanged, overflow <= 1, FSM -> FAULT.
REQ-023 In RUN, pop while empty: depth unchanged, underflow <= 1, FSM -> FAULT.
REQ-024 In FAULT, push and pop SHALL be ignored; storage and depth frozen; fault=1.
REQ-025 clearErr in FAULT: depth <= 0, overflow <= 0, underflow <= 0, FSM -> RUN at that edge.
REQ-026 clearErr in RUN: flush (depth <= 0) and clear both flags; any push/pop in the same cycle is ignored.
REQ-027 depth arithmetic SHALL never wrap: it saturates at 0 and STACK_DEPTH under all input combinations.

Reset
REQ-028 On a clock edge with init_signal=0: FSM=RUN, depth=0, overflow=0, underflow=0; storage contents are don't-care.
REQ-029 Reset SHALL take priority over clearErr, push and pop, including mid-sequence and in FAULT.
REQ-030 Outputs after reset: topOfStack=0, stackEmpty=1, stackFull=0, fault=0.

Structure
REQ-031 STACK_DEPTH, ADDR_W defaults and the FSM state encoding (RUN=0, FAULT=1) SHALL live in the shared processor package.
REQ-032 Storage SHALL be a sub-module stack_mem: STACK_DEPTH x ADDR_W register array with one synchronous write port and one combinational read port; control stays in return_addr_stack.

Verification
REQ-033 Reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> depth=3, topOfStack=0x030; pop -> topOfStack=0x030 during the pop cycle, then 0x020.
REQ-034 Push 8 values 0x100..0x107, then push 0x1FF -> stackFull=1, overflow=1, fault=1, topOfStack=0x107; next pop ignored (depth stays 8).
REQ-035 From reset, pop -> underflow=1, fault=1, depth=0; clearErr -> fault=0, underflow=0, then push 0x055 -> topOfStack=0x055.
REQ-036 depth=2 (0x0A0, 0x0B0), push+pop with pushData=0x0C0 -> depth=2, topOfStack=0x0C0; pop -> topOfStack=0x0A0.
REQ-037 depth=5, assert init_signal=0 together with push -> next cycle depth=0, stackEmpty=1, topOfStack=0.
REQ-038 Random push/pop for 10k cycles against a queue model -> depth, topOfStack and sticky flags match every cycle.
